// File: rtl/ntt_stage_sequencer.sv
// Sequences one NTT/INTT transform: optional psi pre-pass, log2(n) butterfly stages,
// optional psi post-pass. Also gates single-cycle core ops onto the shared modular unit.
module ntt_stage_sequencer #(
    parameter int unsigned PSI_CYCLES = 32,
    parameter int unsigned WAIT_MAX   = 255,
    parameter int unsigned LOGN_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_fwd,
    input  logic [LOGN_W-1:0] cmd_log_n,
    input  logic [LOGN_W-1:0] cmd_first_rounds,
    input  logic              abort,
    input  logic              run_loop,
    input  logic              core_req,
    output logic              core_gnt,
    output logic              ntt_start,
    output logic              single_bf,
    output logic              fwd_ntt,
    output logic              ntt_first_rounds,
    output logic              update_m_single_bf,
    output logic [LOGN_W-1:0] index_single_bf,
    output logic              update_omega_single_bf,
    output logic              mul_psi1,
    output logic              mul_psi2,
    output logic              update_psi,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned PSI_W = $clog2(PSI_CYCLES);
    localparam int unsigned TO_W  = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_CFG_M, S_CFG_W, S_START, S_WAIT_HI, S_WAIT_LO, S_POST, S_FIN
    } state_t;

    state_t              state, state_n;
    logic                fwd_q;
    logic [LOGN_W-1:0]   log_n_q, fr_q, stage, stage_n, fr_sel, idx_q;
    logic [PSI_W-1:0]    psi_cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                first_q, err_q, err_n, legal, in_loop_n;

    assign legal     = (cmd_log_n != '0) && (cmd_log_n <= LOGN_W'(10));
    assign fr_sel    = (state == S_IDLE) ? cmd_first_rounds : fr_q;
    assign in_loop_n = (state_n == S_CFG_M) || (state_n == S_CFG_W) || (state_n == S_START) ||
                       (state_n == S_WAIT_HI) || (state_n == S_WAIT_LO);

    always_comb begin
        state_n                = state;
        stage_n                = stage;
        err_n                  = 1'b0;
        cmd_ready              = 1'b0;
        core_gnt               = 1'b0;
        ntt_start              = 1'b0;
        update_m_single_bf     = 1'b0;
        update_omega_single_bf = 1'b0;
        mul_psi1               = 1'b0;
        mul_psi2               = 1'b0;
        update_psi             = 1'b0;
        done                   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                core_gnt  = core_req && !cmd_valid;
                if (cmd_valid) begin
                    stage_n = '0;
                    if (!legal) err_n   = 1'b1;
                    else        state_n = cmd_fwd ? S_PRE : S_CFG_M;
                end
            end
            S_PRE: begin
                mul_psi1   = 1'b1;
                update_psi = 1'b1;
                if (psi_cnt == PSI_W'(PSI_CYCLES - 1)) state_n = S_CFG_M;
            end
            S_CFG_M: begin
                update_m_single_bf = 1'b1;
                state_n            = S_CFG_W;
            end
            S_CFG_W: begin
                update_omega_single_bf = 1'b1;
                state_n                = S_START;
            end
            S_START: begin
                ntt_start = 1'b1;
                state_n   = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                // a rising run_loop wins over a timeout landing on the same cycle
                if (run_loop) begin
                    state_n = S_WAIT_LO;
                end else if (to_cnt == TO_W'(WAIT_MAX - 1)) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_WAIT_LO: begin
                if (!run_loop) begin
                    stage_n = stage + LOGN_W'(1);
                    if (stage_n < log_n_q) state_n = S_CFG_M;
                    else if (!fwd_q)       state_n = S_POST;
                    else                   state_n = S_FIN;
                end
            end
            S_POST: begin
                mul_psi2   = 1'b1;
                update_psi = 1'b1;
                if (psi_cnt == PSI_W'(PSI_CYCLES - 1)) state_n = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
            err_n   = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            fwd_q   <= 1'b0;
            log_n_q <= '0;
            fr_q    <= '0;
            stage   <= '0;
            psi_cnt <= '0;
            to_cnt  <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            stage <= stage_n;
            err_q <= err_n;
            if ((state == S_IDLE) && cmd_valid) begin
                fwd_q   <= cmd_fwd;
                log_n_q <= cmd_log_n;
                fr_q    <= cmd_first_rounds;
            end
            psi_cnt <= (((state == S_PRE) || (state == S_POST)) && (state_n == state)) ?
                       psi_cnt + PSI_W'(1) : '0;
            to_cnt  <= ((state == S_WAIT_HI) && (state_n == S_WAIT_HI)) ? to_cnt + TO_W'(1) : '0;
            if (state_n == S_CFG_M) idx_q <= stage_n;
            // computed from next-state values so the flag is already valid in CFG_M
            first_q <= in_loop_n && (stage_n < fr_sel);
        end
    end

    assign busy             = (state != S_IDLE);
    assign single_bf        = 1'b0;
    assign fwd_ntt          = fwd_q;
    assign index_single_bf  = idx_q;
    assign ntt_first_rounds = first_q;
    assign err              = err_q;

endmodule
